// File: rtl/tick_bcd_display_if.sv
// Signal bundle between the clock-divider stage / control logic and the BCD tick display.
// The display block is the slave: it consumes the tick and control inputs and drives the count and display outputs.
interface tick_bcd_display_if;
    logic       tick_in;
    logic       tick_locked;
    logic       up_down;
    logic       clear;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       carry;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (
        output tick_in, tick_locked, up_down, clear,
        input  ones, tens, carry, seg, an
    );

    modport slave (
        input  tick_in, tick_locked, up_down, clear,
        output ones, tens, carry, seg, an
    );
endinterface

// File: rtl/tick_bcd_display.sv
// Counts rising edges of the divided tick as a 2-digit BCD value modulo MODULO.
// The count is shown on a multiplexed, active-low 7-segment pair, and every wrap produces a carry pulse.
module tick_bcd_display #(
    parameter int MODULO      = 60,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    tick_bcd_display_if.slave bus
);

    localparam logic [3:0] LAST_TENS = 4'((MODULO - 1) / 10);
    localparam logic [3:0] LAST_ONES = 4'((MODULO - 1) % 10);
    localparam int         RW        = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic          tick_p0, tick_p1, tick_p2;
    logic [1:0]    settle_cnt;
    logic          settled, rise, ev;
    logic [3:0]    ones_q, tens_q;
    logic          carry_q;
    logic [RW-1:0] refresh_cnt;
    logic          digit_sel;
    logic [6:0]    seg_q;
    logic [1:0]    an_q;

    // Stage p0/p1 synchronize the tick; p2 holds the previous synchronized level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_p0 <= 1'b0;
            tick_p1 <= 1'b0;
            tick_p2 <= 1'b0;
        end else begin
            tick_p0 <= bus.tick_in;
            tick_p1 <= tick_p0;
            tick_p2 <= tick_p1;
        end
    end

    // Hold off edge detection until the synchronizer has flushed its post-reset contents
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            settle_cnt <= 2'd0;
        else if (settle_cnt != 2'd3)
            settle_cnt <= settle_cnt + 2'd1;
    end

    assign settled = (settle_cnt == 2'd3);
    assign rise    = tick_p1 & ~tick_p2;
    assign ev      = rise & ~bus.tick_locked & settled;

    // Count stage: clear wins over a coincident event, which is then lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            carry_q <= 1'b0;
        end else begin
            carry_q <= 1'b0;
            if (bus.clear) begin
                ones_q <= 4'd0;
                tens_q <= 4'd0;
            end else if (ev) begin
                if (bus.up_down) begin
                    if (tens_q == LAST_TENS && ones_q == LAST_ONES) begin
                        ones_q  <= 4'd0;
                        tens_q  <= 4'd0;
                        carry_q <= 1'b1;
                    end else if (ones_q == 4'd9) begin
                        ones_q <= 4'd0;
                        tens_q <= tens_q + 4'd1;
                    end else begin
                        ones_q <= ones_q + 4'd1;
                    end
                end else begin
                    if (tens_q == 4'd0 && ones_q == 4'd0) begin
                        ones_q  <= LAST_ONES;
                        tens_q  <= LAST_TENS;
                        carry_q <= 1'b1;
                    end else if (ones_q == 4'd0) begin
                        ones_q <= 4'd9;
                        tens_q <= tens_q - 4'd1;
                    end else begin
                        ones_q <= ones_q - 4'd1;
                    end
                end
            end
        end
    end

    // Refresh timebase: free-running, unaffected by lock or clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt <= '0;
            digit_sel   <= 1'b0;
        end else if (refresh_cnt == REF_LAST) begin
            refresh_cnt <= '0;
            digit_sel   <= ~digit_sel;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Display stage: anode and segment pattern are registered together so no digit ghosts onto its neighbour
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_q  <= 2'b10;
            seg_q <= 7'b1000000;
        end else begin
            an_q  <= digit_sel ? 2'b01 : 2'b10;
            seg_q <= seg_encode(digit_sel ? tens_q : ones_q);
        end
    end

    assign bus.ones  = ones_q;
    assign bus.tens  = tens_q;
    assign bus.carry = carry_q;
    assign bus.seg   = seg_q;
    assign bus.an    = an_q;

endmodule
